// File: rtl/word_serializer.sv
// ============================================================================
// Module   : word_serializer
// Purpose  : Parallel-in/serial-out unload stage with a one-word holding buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module word_serializer #(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         clear_n,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic [N-1:0] in,
    output logic         ser_out,
    output logic         ser_valid,
    input  logic         ser_ready,
    output logic         last,
    output logic         busy
);

    localparam int            CW     = $clog2(N);
    localparam logic [CW-1:0] c_LAST = CW'(N - 1);
    localparam logic [CW-1:0] c_ONE  = CW'(1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t         r_state;
    logic [N-1:0]   r_shreg;
    logic [CW-1:0]  r_count;
    logic [N-1:0]   r_hold;
    logic           r_hold_full;

    logic           w_load_acc;
    logic           w_xfer;
    logic           w_at_last;
    logic [N-1:0]   w_shifted;

    assign w_load_acc = load_valid && !r_hold_full;
    assign w_xfer     = (r_state == S_SHIFT) && ser_ready;
    assign w_at_last  = (r_count == c_LAST);
    assign w_shifted  = MSB_FIRST ? {r_shreg[N-2:0], 1'b0} : {1'b0, r_shreg[N-1:1]};

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_state     <= S_IDLE;
            r_shreg     <= '0;
            r_count     <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_load_acc) begin
                        r_shreg <= in;
                        r_count <= '0;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (w_xfer && w_at_last) begin
                        // Word boundary: the held word wins; load_ready is low then anyway.
                        if (r_hold_full) begin
                            r_shreg     <= r_hold;
                            r_hold_full <= 1'b0;
                            r_count     <= '0;
                        end else if (w_load_acc) begin
                            r_shreg <= in;
                            r_count <= '0;
                        end else begin
                            r_shreg <= '0;
                            r_count <= '0;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        if (w_xfer) begin
                            r_shreg <= w_shifted;
                            r_count <= r_count + c_ONE;
                        end
                        if (w_load_acc) begin
                            r_hold      <= in;
                            r_hold_full <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // The shift register is zeroed on return to idle, so ser_out idles low.
    assign ser_out    = MSB_FIRST ? r_shreg[N-1] : r_shreg[0];
    assign ser_valid  = (r_state == S_SHIFT);
    assign last       = ser_valid && w_at_last;
    assign busy       = ser_valid || r_hold_full;
    assign load_ready = !r_hold_full;

endmodule

`default_nettype wire

// File: tb/tb_word_serializer.sv
// ============================================================================
// Module   : tb_word_serializer
// Purpose  : Scoreboard bench for word_serializer (MSB-first and LSB-first DUTs).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_word_serializer;

    localparam int N = 8;

    logic         clk        = 1'b0;
    logic         clear_n    = 1'b0;
    logic         load_valid = 1'b0;
    logic         ser_ready  = 1'b0;
    logic [N-1:0] din        = '0;

    logic load_ready, ser_out, ser_valid, last, busy;
    logic l_load_ready, l_ser_out, l_ser_valid, l_last, l_busy;

    int checks = 0;
    int errors = 0;

    // Model: words accepted but not yet fully sent, and bits sent of the head word.
    logic [N-1:0] q_words[$];
    int           bit_idx  = 0;
    int           rdy_mode = 0;
    int           rdy_phase = 0;

    always #5 clk = ~clk;

    word_serializer #(.N(N), .MSB_FIRST(1'b1)) u_msb (
        .clk        (clk),
        .clear_n    (clear_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .in         (din),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .ser_ready  (ser_ready),
        .last       (last),
        .busy       (busy)
    );

    word_serializer #(.N(N), .MSB_FIRST(1'b0)) u_lsb (
        .clk        (clk),
        .clear_n    (clear_n),
        .load_valid (load_valid),
        .load_ready (l_load_ready),
        .in         (din),
        .ser_out    (l_ser_out),
        .ser_valid  (l_ser_valid),
        .ser_ready  (ser_ready),
        .last       (l_last),
        .busy       (l_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Downstream ready: 0 = always, 1 = pattern 1,0,0 repeating, 2 = random.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) begin
                ser_ready = 1'b1;
            end else if (rdy_mode == 1) begin
                ser_ready = ((rdy_phase % 3) == 0);
                rdy_phase++;
            end else begin
                ser_ready = 1'($urandom % 2);
            end
        end
    end

    // Monitor/scoreboard: inputs are stable at negedge and equal their values at the next posedge.
    initial begin
        logic [N-1:0] w;
        int           sz;
        forever begin
            @(negedge clk);
            if (!clear_n) begin
                chk("rst_ser_valid", ser_valid, 0);
                chk("rst_ser_out", ser_out, 0);
                chk("rst_last", last, 0);
                chk("rst_busy", busy, 0);
                chk("rst_load_ready", load_ready, 1);
                chk("rst_lsb_busy", l_busy, 0);
                q_words.delete();
                bit_idx = 0;
            end else begin
                sz = q_words.size();
                chk("ser_valid", ser_valid, sz > 0);
                chk("lsb_ser_valid", l_ser_valid, sz > 0);
                chk("load_ready", load_ready, sz < 2);
                chk("lsb_load_ready", l_load_ready, sz < 2);
                chk("busy", busy, sz > 0);
                if (sz > 0) begin
                    w = q_words[0];
                    chk("ser_out_msb", ser_out, w[N-1-bit_idx]);
                    chk("ser_out_lsb", l_ser_out, w[bit_idx]);
                    chk("last", last, bit_idx == N-1);
                    chk("lsb_last", l_last, bit_idx == N-1);
                end else begin
                    chk("last_idle", last, 0);
                end
                if (sz > 0 && ser_ready) begin
                    bit_idx++;
                    if (bit_idx == N) begin
                        void'(q_words.pop_front());
                        bit_idx = 0;
                    end
                end
                if (load_valid && sz < 2) q_words.push_back(din);
            end
        end
    end

    // Presents a word and returns at posedge+1 after the edge that accepts it.
    task automatic load_word(input logic [N-1:0] w);
        int n = 0;
        load_valid = 1'b1;
        din        = w;
        do begin
            @(negedge clk);
            n++;
        end while (!load_ready && n < 200);
        if (!load_ready) begin
            errors++;
            $display("FAIL load_timeout: word %0h not accepted, load_ready %0b required 1", w, load_ready);
        end
        @(posedge clk);
        #1;
        load_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || ser_valid) && n < 400);
        if (busy || ser_valid) begin
            errors++;
            $display("FAIL idle_timeout: busy %0b required 0", busy);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit acc;
        repeat (2) @(posedge clk);
        #2;
        clear_n = 1'b1;

        load_word(8'hA5);
        wait_idle();
        load_word(8'h01);
        wait_idle();

        load_word(8'hF0);
        load_word(8'h0F);
        wait_idle();

        rdy_mode = 1;
        load_word(8'hC3);
        wait_idle();
        rdy_mode = 0;

        // 0x81 arrives exactly on the edge that sends the last bit of 0x7E.
        load_word(8'h7E);
        repeat (7) @(posedge clk);
        #1;
        load_valid = 1'b1;
        din        = 8'h81;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        wait_idle();

        // Asynchronous reset after three bits of 0xFF with 0x55 held.
        load_word(8'hFF);
        load_word(8'h55);
        @(posedge clk);
        @(posedge clk);
        #2;
        clear_n = 1'b0;
        #1;
        chk("async_rst_ser_valid", ser_valid, 0);
        chk("async_rst_ser_out", ser_out, 0);
        chk("async_rst_last", last, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_load_ready", load_ready, 1);
        q_words.delete();
        bit_idx = 0;
        repeat (2) @(posedge clk);
        #2;
        clear_n = 1'b1;
        load_word(8'h33);
        wait_idle();

        rdy_mode = 2;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            acc = load_valid && load_ready;
            @(posedge clk);
            #1;
            if (!load_valid || acc) begin
                load_valid = (($urandom % 3) != 0);
                din        = N'($urandom);
            end
        end
        @(negedge clk);
        acc = load_valid && load_ready;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        rdy_mode   = 0;
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
